// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, entry layout and CDB snoop helper for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int OP_W    = 6;
  localparam int ROB_BIT = 4;
  localparam int DAT_W   = 32;
  localparam int RS_SIZE = 8;
  localparam int RS_BIT  = 3;

  typedef struct packed {
    logic               rdy;
    logic [ROB_BIT-1:0] q;
    logic [DAT_W-1:0]   v;
  } src_t;

  typedef struct packed {
    logic               busy;
    logic [OP_W-1:0]    op;
    logic               ic;
    logic [ROB_BIT-1:0] qd;
    src_t               s;
    src_t               t;
    logic [DAT_W-1:0]   imm;
    logic [DAT_W-1:0]   pc;
  } rs_entry_t;

  // The ALU bus is checked first so it wins if both buses carry the same tag.
  function automatic src_t snoop_src(input src_t cur,
                                     input logic cdb_en, input logic [ROB_BIT-1:0] cdb_q,
                                     input logic [DAT_W-1:0] cdb_v,
                                     input logic lsb_en, input logic [ROB_BIT-1:0] lsb_q,
                                     input logic [DAT_W-1:0] lsb_v);
    src_t res;
    res = cur;
    if (!cur.rdy) begin
      if (cdb_en && (cur.q == cdb_q)) begin
        res.rdy = 1'b1;
        res.v   = cdb_v;
      end else if (lsb_en && (cur.q == lsb_q)) begin
        res.rdy = 1'b1;
        res.v   = lsb_v;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_lowbit_pick.sv
// Lowest-set-bit priority encoder used for free-slot and ready-entry selection.
module rs_lowbit_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds issued instructions until both operands are ready,
// snoops the ALU and load result buses, and dispatches one ready entry per cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush_i,
  input  logic               iss_en_i,
  input  logic [OP_W-1:0]    iss_op_i,
  input  logic               iss_ic_i,
  input  logic [ROB_BIT-1:0] iss_qd_i,
  input  logic [DAT_W-1:0]   iss_vs_i,
  input  logic [DAT_W-1:0]   iss_vt_i,
  input  logic [ROB_BIT-1:0] iss_qs_i,
  input  logic [ROB_BIT-1:0] iss_qt_i,
  input  logic               iss_rs_rdy_i,
  input  logic               iss_rt_rdy_i,
  input  logic [DAT_W-1:0]   iss_imm_i,
  input  logic [DAT_W-1:0]   iss_pc_i,
  input  logic               cdb_en_i,
  input  logic [ROB_BIT-1:0] cdb_q_i,
  input  logic [DAT_W-1:0]   cdb_v_i,
  input  logic               lsb_en_i,
  input  logic [ROB_BIT-1:0] lsb_q_i,
  input  logic [DAT_W-1:0]   lsb_v_i,
  output logic               full_o,
  output logic               alu_en_o,
  output logic [OP_W-1:0]    alu_op_o,
  output logic               alu_ic_o,
  output logic [ROB_BIT-1:0] alu_qd_o,
  output logic [DAT_W-1:0]   alu_vs_o,
  output logic [DAT_W-1:0]   alu_vt_o,
  output logic [DAT_W-1:0]   alu_imm_o,
  output logic [DAT_W-1:0]   alu_pc_o
);

  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  rs_entry_t          ins_ent;
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] ready;
  logic               free_found;
  logic [RS_BIT-1:0]  free_idx;
  logic               rdy_found;
  logic [RS_BIT-1:0]  rdy_idx;

  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy && ent_q[i].s.rdy && ent_q[i].t.rdy;
    end
  end

  assign full_o = &busy;

  rs_lowbit_pick #(.N(RS_SIZE), .W(RS_BIT)) u_free_pick (
    .vec   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_lowbit_pick #(.N(RS_SIZE), .W(RS_BIT)) u_ready_pick (
    .vec   (ready),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  always_comb begin
    ins_ent       = '0;
    ins_ent.busy  = 1'b1;
    ins_ent.op    = iss_op_i;
    ins_ent.ic    = iss_ic_i;
    ins_ent.qd    = iss_qd_i;
    ins_ent.s.rdy = iss_rs_rdy_i;
    ins_ent.s.q   = iss_qs_i;
    ins_ent.s.v   = iss_vs_i;
    ins_ent.t.rdy = iss_rt_rdy_i;
    ins_ent.t.q   = iss_qt_i;
    ins_ent.t.v   = iss_vt_i;
    ins_ent.imm   = iss_imm_i;
    ins_ent.pc    = iss_pc_i;
    ins_ent.s = snoop_src(ins_ent.s, cdb_en_i, cdb_q_i, cdb_v_i, lsb_en_i, lsb_q_i, lsb_v_i);
    ins_ent.t = snoop_src(ins_ent.t, cdb_en_i, cdb_q_i, cdb_v_i, lsb_en_i, lsb_q_i, lsb_v_i);
  end

  // Insert targets a slot that is free now, so it never collides with the
  // dispatched (busy) slot; that slot becomes insertable next cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        ent_d[i].s = snoop_src(ent_q[i].s, cdb_en_i, cdb_q_i, cdb_v_i, lsb_en_i, lsb_q_i, lsb_v_i);
        ent_d[i].t = snoop_src(ent_q[i].t, cdb_en_i, cdb_q_i, cdb_v_i, lsb_en_i, lsb_q_i, lsb_v_i);
      end
    end
    if (rdy_found) ent_d[rdy_idx].busy = 1'b0;
    if (iss_en_i && free_found) ent_d[free_idx] = ins_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_en_o  <= 1'b0;
      alu_op_o  <= '0;
      alu_ic_o  <= 1'b0;
      alu_qd_o  <= '0;
      alu_vs_o  <= '0;
      alu_vt_o  <= '0;
      alu_imm_o <= '0;
      alu_pc_o  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      alu_en_o <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_en_o <= rdy_found;
      if (rdy_found) begin
        alu_op_o  <= ent_q[rdy_idx].op;
        alu_ic_o  <= ent_q[rdy_idx].ic;
        alu_qd_o  <= ent_q[rdy_idx].qd;
        alu_vs_o  <= ent_q[rdy_idx].s.v;
        alu_vt_o  <= ent_q[rdy_idx].t.v;
        alu_imm_o <= ent_q[rdy_idx].imm;
        alu_pc_o  <= ent_q[rdy_idx].pc;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam logic [OP_W-1:0] OP_ADD  = 6'h01;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h13;

  logic               clk = 1'b0;
  logic               rst, en, flush_i;
  logic               iss_en_i, iss_ic_i, iss_rs_rdy_i, iss_rt_rdy_i;
  logic [OP_W-1:0]    iss_op_i;
  logic [ROB_BIT-1:0] iss_qd_i, iss_qs_i, iss_qt_i;
  logic [DAT_W-1:0]   iss_vs_i, iss_vt_i, iss_imm_i, iss_pc_i;
  logic               cdb_en_i, lsb_en_i;
  logic [ROB_BIT-1:0] cdb_q_i, lsb_q_i;
  logic [DAT_W-1:0]   cdb_v_i, lsb_v_i;
  logic               full_o, alu_en_o, alu_ic_o;
  logic [OP_W-1:0]    alu_op_o;
  logic [ROB_BIT-1:0] alu_qd_o;
  logic [DAT_W-1:0]   alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
    .iss_en_i(iss_en_i), .iss_op_i(iss_op_i), .iss_ic_i(iss_ic_i), .iss_qd_i(iss_qd_i),
    .iss_vs_i(iss_vs_i), .iss_vt_i(iss_vt_i), .iss_qs_i(iss_qs_i), .iss_qt_i(iss_qt_i),
    .iss_rs_rdy_i(iss_rs_rdy_i), .iss_rt_rdy_i(iss_rt_rdy_i),
    .iss_imm_i(iss_imm_i), .iss_pc_i(iss_pc_i),
    .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
    .lsb_en_i(lsb_en_i), .lsb_q_i(lsb_q_i), .lsb_v_i(lsb_v_i),
    .full_o(full_o), .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o),
    .alu_qd_o(alu_qd_o), .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o),
    .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i  = 1'b0;
    iss_en_i = 1'b0;
    cdb_en_i = 1'b0;
    lsb_en_i = 1'b0;
  endtask

  task automatic drive_issue(input logic [OP_W-1:0] op, input logic [ROB_BIT-1:0] qd,
                             input logic [DAT_W-1:0] vs, input logic [ROB_BIT-1:0] qs,
                             input logic rs_rdy, input logic [DAT_W-1:0] vt,
                             input logic [ROB_BIT-1:0] qt, input logic rt_rdy,
                             input logic [DAT_W-1:0] imm, input logic [DAT_W-1:0] pc);
    iss_en_i = 1'b1; iss_op_i = op; iss_ic_i = 1'b0; iss_qd_i = qd;
    iss_vs_i = vs; iss_qs_i = qs; iss_rs_rdy_i = rs_rdy;
    iss_vt_i = vt; iss_qt_i = qt; iss_rt_rdy_i = rt_rdy;
    iss_imm_i = imm; iss_pc_i = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; idle();
    iss_op_i = '0; iss_ic_i = 1'b0; iss_qd_i = '0; iss_vs_i = '0; iss_vt_i = '0;
    iss_qs_i = '0; iss_qt_i = '0; iss_rs_rdy_i = 1'b0; iss_rt_rdy_i = 1'b0;
    iss_imm_i = '0; iss_pc_i = '0; cdb_q_i = '0; cdb_v_i = '0; lsb_q_i = '0; lsb_v_i = '0;
    tick(); tick();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %0h want 0", alu_en_o); end
    n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0h want 0", full_o); end
    n_checks++; if ({alu_op_o, alu_ic_o, alu_qd_o} !== '0) begin n_fail++; $display("FAIL reset_op_ic_qd: got %0h want 0", {alu_op_o, alu_ic_o, alu_qd_o}); end
    n_checks++; if ({alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o} !== '0) begin n_fail++; $display("FAIL reset_payload: got %0h want 0", {alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ready_issue();
    drive_issue(OP_ADDI, 4'd3, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd7, 32'h100);
    tick();
    idle();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL ready_min_residency: got %0h want 0", alu_en_o); end
    tick();
    n_checks++; if (alu_en_o !== 1'b1) begin n_fail++; $display("FAIL ready_dispatch_en: got %0h want 1", alu_en_o); end
    n_checks++; if (alu_vs_o !== 32'd5) begin n_fail++; $display("FAIL ready_vs: got %0h want 5", alu_vs_o); end
    n_checks++; if (alu_imm_o !== 32'd7) begin n_fail++; $display("FAIL ready_imm: got %0h want 7", alu_imm_o); end
    n_checks++; if (alu_qd_o !== 4'd3) begin n_fail++; $display("FAIL ready_qd: got %0h want 3", alu_qd_o); end
    n_checks++; if (alu_op_o !== OP_ADDI) begin n_fail++; $display("FAIL ready_op: got %0h want %0h", alu_op_o, OP_ADDI); end
    n_checks++; if (alu_pc_o !== 32'h100) begin n_fail++; $display("FAIL ready_pc: got %0h want 100", alu_pc_o); end
    tick();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL ready_single_pulse: got %0h want 0", alu_en_o); end
  endtask

  task automatic test_wakeup();
    drive_issue(OP_ADD, 4'd5, 32'd0, 4'd4, 1'b0, 32'd2, 4'd0, 1'b1, 32'd0, 32'h200);
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL wake_waiting: got %0h want 0", alu_en_o); end
    end
    cdb_en_i = 1'b1; cdb_q_i = 4'd4; cdb_v_i = 32'h10;
    tick();
    idle();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL wake_same_edge: got %0h want 0", alu_en_o); end
    tick();
    n_checks++; if (alu_en_o !== 1'b1) begin n_fail++; $display("FAIL wake_dispatch_en: got %0h want 1", alu_en_o); end
    n_checks++; if (alu_vs_o !== 32'h10) begin n_fail++; $display("FAIL wake_vs: got %0h want 10", alu_vs_o); end
    n_checks++; if (alu_vt_o !== 32'd2) begin n_fail++; $display("FAIL wake_vt: got %0h want 2", alu_vt_o); end
    n_checks++; if (alu_qd_o !== 4'd5) begin n_fail++; $display("FAIL wake_qd: got %0h want 5", alu_qd_o); end
    tick();
  endtask

  task automatic test_bypass();
    drive_issue(OP_ADD, 4'd7, 32'd1, 4'd0, 1'b1, 32'd0, 4'd6, 1'b0, 32'd0, 32'h300);
    lsb_en_i = 1'b1; lsb_q_i = 4'd6; lsb_v_i = 32'd9;
    tick();
    idle();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL bypass_residency: got %0h want 0", alu_en_o); end
    tick();
    n_checks++; if (alu_en_o !== 1'b1) begin n_fail++; $display("FAIL bypass_dispatch_en: got %0h want 1", alu_en_o); end
    n_checks++; if (alu_vt_o !== 32'd9) begin n_fail++; $display("FAIL bypass_vt: got %0h want 9", alu_vt_o); end
    n_checks++; if (alu_qd_o !== 4'd7) begin n_fail++; $display("FAIL bypass_qd: got %0h want 7", alu_qd_o); end
    tick();
  endtask

  task automatic test_full_order();
    for (int k = 0; k < 8; k++) begin
      drive_issue(OP_ADD, 4'(k + 8), 32'd0, 4'd1, 1'b0, 32'd3, 4'd0, 1'b1, 32'(k), 32'(k * 4));
      tick();
      n_checks++; if (full_o !== (k == 7)) begin n_fail++; $display("FAIL fill_full_%0d: got %0h want %0h", k, full_o, (k == 7)); end
    end
    drive_issue(OP_ADDI, 4'd2, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 32'h0);
    tick();
    idle();
    n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL full_after_drop: got %0h want 1", full_o); end
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL full_no_dispatch: got %0h want 0", alu_en_o); end
    cdb_en_i = 1'b1; cdb_q_i = 4'd1; cdb_v_i = 32'h55;
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (alu_en_o !== 1'b1) begin n_fail++; $display("FAIL order_en_%0d: got %0h want 1", k, alu_en_o); end
      n_checks++; if (alu_qd_o !== 4'(k + 8)) begin n_fail++; $display("FAIL order_qd_%0d: got %0h want %0h", k, alu_qd_o, k + 8); end
      n_checks++; if (alu_vs_o !== 32'h55) begin n_fail++; $display("FAIL order_vs_%0d: got %0h want 55", k, alu_vs_o); end
      n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL order_full_%0d: got %0h want 0", k, full_o); end
    end
    tick();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL dropped_not_stored: got %0h want 0", alu_en_o); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive_issue(OP_ADD, 4'(k + 1), 32'd0, 4'd7, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 32'h0);
      tick();
    end
    idle();
    cdb_en_i = 1'b1; cdb_q_i = 4'd7; cdb_v_i = 32'h77;
    tick();
    idle();
    flush_i = 1'b1;
    drive_issue(OP_ADDI, 4'd4, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 32'h0);
    tick();
    idle();
    n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_alu_en: got %0h want 0", alu_en_o); end
    n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %0h want 0", full_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty_%0d: got %0h want 0", k, alu_en_o); end
    end
  endtask

  task automatic test_stall();
    drive_issue(OP_ADDI, 4'd10, 32'h33, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd1, 32'h400);
    tick();
    drive_issue(OP_ADDI, 4'd11, 32'h44, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd2, 32'h404);
    tick();
    n_checks++; if ({alu_en_o, alu_qd_o} !== {1'b1, 4'd10}) begin n_fail++; $display("FAIL stall_first: got %0h want 1a", {alu_en_o, alu_qd_o}); end
    en = 1'b0;
    drive_issue(OP_ADDI, 4'd12, 32'h55, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd3, 32'h408);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (alu_en_o !== 1'b1) begin n_fail++; $display("FAIL stall_en_%0d: got %0h want 1", k, alu_en_o); end
      n_checks++; if (alu_qd_o !== 4'd10) begin n_fail++; $display("FAIL stall_qd_%0d: got %0h want a", k, alu_qd_o); end
      n_checks++; if (alu_vs_o !== 32'h33) begin n_fail++; $display("FAIL stall_vs_%0d: got %0h want 33", k, alu_vs_o); end
    end
    en = 1'b1;
    idle();
    tick();
    n_checks++; if ({alu_en_o, alu_qd_o} !== {1'b1, 4'd11}) begin n_fail++; $display("FAIL stall_resume: got %0h want 1b", {alu_en_o, alu_qd_o}); end
    n_checks++; if (alu_vs_o !== 32'h44) begin n_fail++; $display("FAIL stall_resume_vs: got %0h want 44", alu_vs_o); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (alu_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_once_%0d: got %0h want 0", k, alu_en_o); end
    end
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_full_order();
    test_flush();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
